// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-port memory between an instruction-fetch requester and a
//   data requester. Exactly one transaction is outstanding at a time. A grant
//   is issued combinationally in IDLE. The memory answers one cycle later, and
//   that answer is returned as a one-cycle Valid pulse. Ties go round-robin.
//   The winner of the first tie after reset is the fetch side.
//
// Ports
//   i_Clock, i_Reset                 clock, asynchronous active-high reset
//   i_Ifetch_Req / i_Ifetch_Addr     fetch request and address
//   o_Ifetch_Ready / _Valid / _Data  fetch accept, data-valid pulse, data
//   i_Dmem_Req / _Write_Enable / _Addr / _Data / _Load_Store_Type
//                                    data request and access attributes
//   o_Dmem_Ready / _Valid / _Data    data accept, completion pulse, read data
//   o_Mem_Enable / _Write_Enable / _Addr / _Data / _Load_Store_Type
//                                    shared memory command (all zero when idle)
//   i_Mem_Data                       memory read data, one cycle after enable
//   o_Conflict_Count                 saturating count of IDLE cycles with both
//                                    requesters pending
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LS_WIDTH   = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,

  input  logic                  i_Ifetch_Req,
  input  logic [ADDR_WIDTH-1:0] i_Ifetch_Addr,
  output logic                  o_Ifetch_Ready,
  output logic                  o_Ifetch_Valid,
  output logic [DATA_WIDTH-1:0] o_Ifetch_Data,

  input  logic                  i_Dmem_Req,
  input  logic                  i_Dmem_Write_Enable,
  input  logic [ADDR_WIDTH-1:0] i_Dmem_Addr,
  input  logic [DATA_WIDTH-1:0] i_Dmem_Data,
  input  logic [LS_WIDTH-1:0]   i_Dmem_Load_Store_Type,
  output logic                  o_Dmem_Ready,
  output logic                  o_Dmem_Valid,
  output logic [DATA_WIDTH-1:0] o_Dmem_Data,

  output logic                  o_Mem_Enable,
  output logic                  o_Mem_Write_Enable,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_Data,
  output logic [LS_WIDTH-1:0]   o_Mem_Load_Store_Type,
  input  logic [DATA_WIDTH-1:0] i_Mem_Data,

  output logic [15:0]           o_Conflict_Count
);

  typedef enum logic [1:0] {
    IDLE,
    IFETCH_WAIT,
    DMEM_WAIT
  } state_t;

  typedef enum logic {
    GRANT_IFETCH,
    GRANT_DMEM
  } grant_t;

  state_t                r_State, w_Next_State;
  grant_t                r_Last_Grant, w_Next_Last_Grant;
  logic                  w_Grant_Ifetch;
  logic                  w_Grant_Dmem;
  logic                  w_Tie;
  logic [DATA_WIDTH-1:0] r_Ifetch_Data_Hold;
  logic [DATA_WIDTH-1:0] r_Dmem_Data_Hold;
  logic [15:0]           r_Conflict_Count;

  // State register and round-robin history
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State      <= IDLE;
      r_Last_Grant <= GRANT_DMEM;
    end else begin
      r_State      <= w_Next_State;
      r_Last_Grant <= w_Next_Last_Grant;
    end
  end

  // Grant decision, memory command, handshakes and next state
  always_comb begin
    w_Next_State          = r_State;
    w_Next_Last_Grant     = r_Last_Grant;
    w_Grant_Ifetch        = 1'b0;
    w_Grant_Dmem          = 1'b0;
    w_Tie                 = 1'b0;
    o_Ifetch_Ready        = 1'b0;
    o_Dmem_Ready          = 1'b0;
    o_Ifetch_Valid        = 1'b0;
    o_Dmem_Valid          = 1'b0;
    o_Mem_Enable          = 1'b0;
    o_Mem_Write_Enable    = 1'b0;
    o_Mem_Addr            = '0;
    o_Mem_Data            = '0;
    o_Mem_Load_Store_Type = '0;

    case (r_State)
      IDLE: begin
        w_Tie = i_Ifetch_Req && i_Dmem_Req;
        if (w_Tie) begin
          // Whoever did not win last time takes the tie
          w_Grant_Ifetch = (r_Last_Grant == GRANT_DMEM);
          w_Grant_Dmem   = (r_Last_Grant == GRANT_IFETCH);
        end else begin
          w_Grant_Ifetch = i_Ifetch_Req;
          w_Grant_Dmem   = i_Dmem_Req;
        end

        if (w_Grant_Ifetch) begin
          o_Ifetch_Ready    = 1'b1;
          o_Mem_Enable      = 1'b1;
          o_Mem_Addr        = i_Ifetch_Addr;
          w_Next_State      = IFETCH_WAIT;
          w_Next_Last_Grant = GRANT_IFETCH;
        end else if (w_Grant_Dmem) begin
          o_Dmem_Ready          = 1'b1;
          o_Mem_Enable          = 1'b1;
          o_Mem_Write_Enable    = i_Dmem_Write_Enable;
          o_Mem_Addr            = i_Dmem_Addr;
          o_Mem_Data            = i_Dmem_Data;
          o_Mem_Load_Store_Type = i_Dmem_Load_Store_Type;
          w_Next_State          = DMEM_WAIT;
          w_Next_Last_Grant     = GRANT_DMEM;
        end
      end

      IFETCH_WAIT: begin
        o_Ifetch_Valid = 1'b1;
        w_Next_State   = IDLE;
      end

      DMEM_WAIT: begin
        o_Dmem_Valid = 1'b1;
        w_Next_State = IDLE;
      end

      default: w_Next_State = IDLE;
    endcase
  end

  // Returned data passes straight through on the Valid cycle and is held after
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Ifetch_Data_Hold <= '0;
      r_Dmem_Data_Hold   <= '0;
    end else begin
      if (r_State == IFETCH_WAIT) r_Ifetch_Data_Hold <= i_Mem_Data;
      if (r_State == DMEM_WAIT)   r_Dmem_Data_Hold   <= i_Mem_Data;
    end
  end

  assign o_Ifetch_Data = o_Ifetch_Valid ? i_Mem_Data : r_Ifetch_Data_Hold;
  assign o_Dmem_Data   = o_Dmem_Valid   ? i_Mem_Data : r_Dmem_Data_Hold;

  // Saturating conflict counter
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Conflict_Count <= '0;
    end else if (w_Tie && (r_Conflict_Count != '1)) begin
      r_Conflict_Count <= r_Conflict_Count + 16'd1;
    end
  end

  assign o_Conflict_Count = r_Conflict_Count;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 3;

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Ifetch_Req = 1'b0;
  logic [AW-1:0] i_Ifetch_Addr = '0;
  logic          o_Ifetch_Ready, o_Ifetch_Valid;
  logic [DW-1:0] o_Ifetch_Data;
  logic          i_Dmem_Req = 1'b0;
  logic          i_Dmem_Write_Enable = 1'b0;
  logic [AW-1:0] i_Dmem_Addr = '0;
  logic [DW-1:0] i_Dmem_Data = '0;
  logic [LW-1:0] i_Dmem_Load_Store_Type = '0;
  logic          o_Dmem_Ready, o_Dmem_Valid;
  logic [DW-1:0] o_Dmem_Data;
  logic          o_Mem_Enable, o_Mem_Write_Enable;
  logic [AW-1:0] o_Mem_Addr;
  logic [DW-1:0] o_Mem_Data;
  logic [LW-1:0] o_Mem_Load_Store_Type;
  logic [DW-1:0] i_Mem_Data;
  logic [15:0]   o_Conflict_Count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_Clock = ~i_Clock;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LS_WIDTH(LW)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Ifetch_Req(i_Ifetch_Req), .i_Ifetch_Addr(i_Ifetch_Addr),
    .o_Ifetch_Ready(o_Ifetch_Ready), .o_Ifetch_Valid(o_Ifetch_Valid),
    .o_Ifetch_Data(o_Ifetch_Data),
    .i_Dmem_Req(i_Dmem_Req), .i_Dmem_Write_Enable(i_Dmem_Write_Enable),
    .i_Dmem_Addr(i_Dmem_Addr), .i_Dmem_Data(i_Dmem_Data),
    .i_Dmem_Load_Store_Type(i_Dmem_Load_Store_Type),
    .o_Dmem_Ready(o_Dmem_Ready), .o_Dmem_Valid(o_Dmem_Valid),
    .o_Dmem_Data(o_Dmem_Data),
    .o_Mem_Enable(o_Mem_Enable), .o_Mem_Write_Enable(o_Mem_Write_Enable),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Data(o_Mem_Data),
    .o_Mem_Load_Store_Type(o_Mem_Load_Store_Type),
    .i_Mem_Data(i_Mem_Data),
    .o_Conflict_Count(o_Conflict_Count)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory: read data appears the cycle after the enabled read command
  always @(posedge i_Clock)
    if (o_Mem_Enable && !o_Mem_Write_Enable) i_Mem_Data <= mem_fn(o_Mem_Addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level model: pending = which requester awaits its reply
  int          m_pend;     // 0 none, 1 fetch, 2 data
  int          win;
  bit          m_last_d;
  bit          m_pread;
  bit          m_dknown;
  logic [15:0] m_cnt;
  logic [31:0] m_addr, m_ihold, m_dhold;
  logic [31:0] e_addr, e_data;
  logic [2:0]  e_ls;
  logic        e_we;

  always @(negedge i_Clock) begin
    if (i_Reset) begin
      check("rst_ifetch_ready", o_Ifetch_Ready, 0);
      check("rst_ifetch_valid", o_Ifetch_Valid, 0);
      check("rst_ifetch_data", o_Ifetch_Data, 0);
      check("rst_dmem_ready", o_Dmem_Ready, 0);
      check("rst_dmem_valid", o_Dmem_Valid, 0);
      check("rst_dmem_data", o_Dmem_Data, 0);
      check("rst_mem_enable", o_Mem_Enable, 0);
      check("rst_conflict", o_Conflict_Count, 0);
      m_pend = 0; m_last_d = 1; m_cnt = 0; m_ihold = 0; m_dhold = 0;
      m_dknown = 1; m_pread = 0; m_addr = 0;
    end else begin
      win = 0;
      if (m_pend == 0) begin
        if (i_Ifetch_Req && i_Dmem_Req) win = m_last_d ? 1 : 2;
        else if (i_Ifetch_Req)          win = 1;
        else if (i_Dmem_Req)            win = 2;
      end
      e_we = 0; e_addr = 0; e_data = 0; e_ls = 0;
      if (win == 1) e_addr = i_Ifetch_Addr;
      if (win == 2) begin
        e_we = i_Dmem_Write_Enable; e_addr = i_Dmem_Addr;
        e_data = i_Dmem_Data; e_ls = i_Dmem_Load_Store_Type;
      end
      check("ifetch_ready", o_Ifetch_Ready, win == 1);
      check("dmem_ready", o_Dmem_Ready, win == 2);
      check("mem_enable", o_Mem_Enable, win != 0);
      check("mem_we", o_Mem_Write_Enable, e_we);
      check("mem_addr", o_Mem_Addr, e_addr);
      check("mem_ls", o_Mem_Load_Store_Type, e_ls);
      if (win != 1) check("mem_data", o_Mem_Data, e_data);
      check("ifetch_valid", o_Ifetch_Valid, m_pend == 1);
      check("dmem_valid", o_Dmem_Valid, m_pend == 2);
      check("ifetch_data", o_Ifetch_Data, (m_pend == 1) ? mem_fn(m_addr) : m_ihold);
      if (m_pend == 2 && m_pread) check("dmem_rdata", o_Dmem_Data, mem_fn(m_addr));
      else if (m_pend != 2 && m_dknown) check("dmem_hold", o_Dmem_Data, m_dhold);
      check("conflict_count", o_Conflict_Count, m_cnt);

      if (m_pend == 1) m_ihold = mem_fn(m_addr);
      if (m_pend == 2) begin
        m_dknown = m_pread;
        if (m_pread) m_dhold = mem_fn(m_addr);
      end
      if (m_pend == 0 && i_Ifetch_Req && i_Dmem_Req && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_pend = win;
      if (win != 0) begin
        m_last_d = (win == 2);
        m_addr   = e_addr;
        m_pread  = (win == 1) || !i_Dmem_Write_Enable;
      end
    end
  end

  task automatic sync();
    @(posedge i_Clock); #1;
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    bit got = 0;
    i_Ifetch_Req = 1; i_Ifetch_Addr = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_Clock);
      got = o_Ifetch_Ready;
    end
    check("ifetch_grant_bound", got, 1);
    sync();
    i_Ifetch_Req = 0; i_Ifetch_Addr = '0;
  endtask

  task automatic dmem_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] ls);
    bit got = 0;
    i_Dmem_Req = 1; i_Dmem_Write_Enable = we; i_Dmem_Addr = a;
    i_Dmem_Data = d; i_Dmem_Load_Store_Type = ls;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_Clock);
      got = o_Dmem_Ready;
    end
    check("dmem_grant_bound", got, 1);
    sync();
    i_Dmem_Req = 0; i_Dmem_Write_Enable = 0; i_Dmem_Addr = '0;
    i_Dmem_Data = '0; i_Dmem_Load_Store_Type = '0;
  endtask

  logic [7:0] gi, gd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_Clock);
    sync();
    i_Reset = 0;

    // Single fetch with hand-computed return value
    fork
      fetch_txn(32'h10);
      begin
        @(negedge i_Clock);
        check("t1_ready", o_Ifetch_Ready, 1);
        check("t1_addr", o_Mem_Addr, 32'h10);
        @(negedge i_Clock);
        check("t1_valid", o_Ifetch_Valid, 1);
        check("t1_data", o_Ifetch_Data, 32'h00500093);
        @(negedge i_Clock);
        check("t1_valid_off", o_Ifetch_Valid, 0);
        check("t1_hold", o_Ifetch_Data, 32'h00500093);
      end
    join

    // Tie straight out of reset: fetch first, data two cycles later
    sync();
    i_Reset = 1;
    sync();
    i_Reset = 0;
    fork
      fetch_txn(32'h0);
      dmem_txn(0, 32'h100, 32'h0, 3'd2);
      begin
        @(negedge i_Clock);
        check("t2_ifetch_first", o_Ifetch_Ready, 1);
        check("t2_dmem_waits", o_Dmem_Ready, 0);
        @(negedge i_Clock);
        check("t2_count_after_tie", o_Conflict_Count, 16'd1);
        @(negedge i_Clock);
        check("t2_dmem_granted", o_Dmem_Ready, 1);
        check("t2_dmem_addr", o_Mem_Addr, 32'h100);
        check("t2_count_still", o_Conflict_Count, 16'd1);
      end
    join

    // Continuous contention: grants alternate I, D, I, D
    sync();
    fork
      begin fetch_txn(32'h20); fetch_txn(32'h24); end
      begin dmem_txn(0, 32'h300, 32'h0, 3'd2); dmem_txn(0, 32'h304, 32'h0, 3'd1); end
      for (int i = 0; i < 8; i++) begin
        @(negedge i_Clock);
        gi[i] = o_Ifetch_Ready;
        gd[i] = o_Dmem_Ready;
      end
    join
    check("t3_ifetch_grants", gi, 8'b0001_0001);
    check("t3_dmem_grants", gd, 8'b0100_0100);

    // Store word
    sync();
    fork
      dmem_txn(1, 32'h200, 32'hDEADBEEF, 3'd0);
      begin
        @(negedge i_Clock);
        check("t4_ready", o_Dmem_Ready, 1);
        check("t4_we", o_Mem_Write_Enable, 1);
        check("t4_addr", o_Mem_Addr, 32'h200);
        check("t4_data", o_Mem_Data, 32'hDEADBEEF);
        check("t4_ls", o_Mem_Load_Store_Type, 3'd0);
        @(negedge i_Clock);
        check("t4_valid", o_Dmem_Valid, 1);
      end
    join

    // Reset while waiting for fetch data abandons the transaction
    sync();
    fork
      fetch_txn(32'h40);
      begin
        @(negedge i_Clock);
        check("t5_ready", o_Ifetch_Ready, 1);
        sync();
        i_Reset = 1;
        @(negedge i_Clock);
        check("t5_valid_in_reset", o_Ifetch_Valid, 0);
        check("t5_data_in_reset", o_Ifetch_Data, 0);
        check("t5_mem_en_in_reset", o_Mem_Enable, 0);
        sync();
        i_Reset = 0;
        for (int i = 0; i < 2; i++) begin
          @(negedge i_Clock);
          check("t5_no_valid_after", o_Ifetch_Valid, 0);
        end
      end
    join

    // Saturation: start the counter just below the top
    sync();
    force dut.r_Conflict_Count = 16'hFFFD;
    m_cnt = 16'hFFFD;
    @(negedge i_Clock);
    sync();
    release dut.r_Conflict_Count;
    fork
      begin fetch_txn(32'h50); fetch_txn(32'h54); fetch_txn(32'h58); end
      begin
        dmem_txn(0, 32'h500, 32'h0, 3'd2);
        dmem_txn(0, 32'h504, 32'h0, 3'd2);
        dmem_txn(0, 32'h508, 32'h0, 3'd2);
      end
    join
    @(negedge i_Clock);
    check("t6_saturated", o_Conflict_Count, 16'hFFFF);

    repeat (2) @(negedge i_Clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
